// File: rtl/result_reader_if.sv
// Drain-request, output-buffer read and row-stream signals of result_reader.
// The slave modport is the reader itself; master is the surrounding system.
interface result_reader_if #(
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM     = 32
);
    logic                                                  req_valid;
    logic                                                  req_ready;
    logic [ADDR_WIDTH-1:0]                                 req_addr;
    logic [4:0]                                            req_rows;
    logic [4:0]                                            req_cols;
    logic                                                  rd_en;
    logic [ADDR_WIDTH-1:0]                                 rd_addr;
    logic [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH_ACCUM-1:0] rd_data;
    logic                                                  out_valid;
    logic                                                  out_ready;
    logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0]      out_data;
    logic                                                  out_last;
    logic                                                  busy;
    logic                                                  done;

    modport master (
        output req_valid, req_addr, req_rows, req_cols, rd_data, out_ready,
        input  req_ready, rd_en, rd_addr, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  req_valid, req_addr, req_rows, req_cols, rd_data, out_ready,
        output req_ready, rd_en, rd_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/result_reader.sv
// Drains result rows from the output buffer into a column-masked row stream.
// Define RESULT_READER_CLAMP8_EN to saturate each unmasked lane to signed 8 bits.
module result_reader #(
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM     = 32
) (
    input logic            clk,
    input logic            rst_n,
    result_reader_if.slave bus
);
    localparam int W  = SYSTOLIC_ARRAY_WIDTH;
    localparam int DW = DATA_WIDTH_ACCUM;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] base_q, base_next;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_next;
    logic [4:0]            rows_q, rows_next;
    logic [4:0]            cols_q, cols_next;
    logic [4:0]            issue_cnt, issue_next;
    logic [4:0]            beat_cnt, beat_next;
    logic                  rd_en_q, rd_en_next;
    logic                  done_q, done_next;
    logic                  rd_valid_q;

    logic [W-1:0][DW-1:0]  mem [3];
    logic [1:0]            wr_ptr, rd_ptr, count;
    logic [2:0]            occupancy;
    logic                  push, pop, accept, can_issue, last_beat, out_valid;
    logic [4:0]            clamped_rows;
    logic [W*DW-1:0]       row_out;

`ifdef RESULT_READER_CLAMP8_EN
    localparam logic signed [DW-1:0] SAT_HI = DW'(127);
    localparam logic signed [DW-1:0] SAT_LO = -(DW'(128));

    function automatic logic [DW-1:0] sat8(input logic [DW-1:0] v);
        logic signed [DW-1:0] s;
        s = $signed(v);
        if (s > SAT_HI)      return SAT_HI;
        else if (s < SAT_LO) return SAT_LO;
        else                 return v;
    endfunction
`endif

    assign accept       = bus.req_valid && (state == IDLE);
    assign clamped_rows = (bus.req_rows > 5'd16) ? 5'd16 : bus.req_rows;
    assign out_valid    = (count != 2'd0);
    assign push         = rd_valid_q;
    assign pop          = out_valid && bus.out_ready;
    assign last_beat    = (beat_cnt == rows_q - 5'd1);

    // Issue decision is registered: every read already scheduled or buffered,
    // plus the one being scheduled, must fit in the 3 FIFO slots next cycle.
    assign occupancy = {1'b0, count} + {2'b0, rd_valid_q} + {2'b0, rd_en_q};
    assign can_issue = (occupancy <= (3'd2 + {2'b0, pop}));

    always_comb begin
        state_next   = state;
        base_next    = base_q;
        rows_next    = rows_q;
        cols_next    = cols_q;
        issue_next   = issue_cnt;
        beat_next    = pop ? beat_cnt + 5'd1 : beat_cnt;
        rd_en_next   = 1'b0;
        rd_addr_next = rd_addr_q;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    base_next = bus.req_addr;
                    rows_next = clamped_rows;
                    cols_next = bus.req_cols;
                    beat_next = '0;
                    if (clamped_rows == 5'd0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next   = READ;
                        rd_en_next   = 1'b1;
                        rd_addr_next = bus.req_addr;
                        issue_next   = 5'd1;
                    end
                end
            end
            READ: begin
                if (issue_cnt == rows_q) begin
                    state_next = DRAIN;
                end else if (can_issue) begin
                    rd_en_next   = 1'b1;
                    rd_addr_next = base_q + ADDR_WIDTH'(issue_cnt);
                    issue_next   = issue_cnt + 5'd1;
                end
            end
            DRAIN: begin
                if (pop && last_beat) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_next;
            base_q    <= base_next;
            rows_q    <= rows_next;
            cols_q    <= cols_next;
            issue_cnt <= issue_next;
            beat_cnt  <= beat_next;
            rd_en_q   <= rd_en_next;
            rd_addr_q <= rd_addr_next;
            done_q    <= done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            rd_valid_q <= rd_en_q;
            if (push) wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            if (pop)  rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.rd_data;
    end

    // Masking is applied on the way out, so buffered rows stay raw.
    always_comb begin
        row_out = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (out_valid && (i < 32'(cols_q))) begin
`ifdef RESULT_READER_CLAMP8_EN
                row_out[i*DW +: DW] = sat8(mem[rd_ptr][i]);
`else
                row_out[i*DW +: DW] = mem[rd_ptr][i];
`endif
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = row_out;
    assign bus.out_last  = out_valid && last_beat;
endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, output-buffer row address width.
REQ-002 The block SHALL have parameter SYSTOLIC_ARRAY_WIDTH (W), default 16, lanes per row.
REQ-003 The block SHALL have parameter DATA_WIDTH_ACCUM, default 32, lane width in bits.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have ports req_valid/req_ready  input/output  1/1  drain-request handshake.
REQ-007 The block SHALL have port req_addr  input  ADDR_WIDTH  first result row address (the task's D address).
REQ-008 The block SHALL have ports req_rows/req_cols  input  5/5  rows to read / valid columns.
REQ-009 The block SHALL have ports rd_en/rd_addr  output  1/ADDR_WIDTH  read port to the output buffer (axim_rd_en_in/axim_rd_addr_in).
REQ-010 The block SHALL have port rd_data  input  W x DATA_WIDTH_ACCUM signed  row data, valid exactly one cycle after rd_en.
REQ-011 The block SHALL have ports out_valid/out_ready  output/input  1/1  row-stream handshake.
REQ-012 The block SHALL have ports out_data/out_last  output  W*DATA_WIDTH_ACCUM/1  packed row (lane 0 in LSBs) / final row of request.
REQ-013 The block SHALL have ports busy/done  output  1/1  request in progress / one-cycle completion pulse.

Function
REQ-014 States SHALL be IDLE, READ (issuing reads), DRAIN (all reads issued, FIFO emptying); busy=1 outside IDLE.
REQ-015 req_ready SHALL be 1 only in IDLE; accept (req_valid&req_ready) latches addr, rows, cols and moves to READ.
REQ-016 req_rows=0 SHALL go directly to IDLE with done=1 in the cycle after accept, no reads, no beats; req_rows>16 SHALL be clamped to 16.
REQ-017 With accept in cycle 0 and out_ready=1: rd_en=1, rd_addr=req_addr in cycle 1; data captured end of cycle 2; out_valid=1 in cycle 3; one row per cycle thereafter.
REQ-018 Row i SHALL be read from (req_addr+i) mod 2^ADDR_WIDTH (wrap-around, no error).
REQ-019 Read data SHALL enter a 3-entry FIFO; rd_en SHALL assert only when FIFO occupancy plus in-flight reads < 3, so no data is ever dropped under backpressure.
REQ-020 out_data/out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Lanes with index >= req_cols SHALL be output as 0; req_cols>=16 passes all lanes; req_cols=0 zeroes all lanes.
REQ-022 out_last SHALL be 1 exactly on the beat of row req_rows-1.
REQ-023 READ->DRAIN after the last rd_en; DRAIN->IDLE on the out_last handshake; done=1 in the following cycle, req_ready=1 in that same cycle.
REQ-024 rd_en SHALL be 0 in IDLE and DRAIN; rd_addr SHALL hold its last value when rd_en=0.

Reset
REQ-025 On rst_n=0, immediately: state IDLE, FIFO empty, in-flight reads discarded, rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, req_ready=1 after release.
REQ-026 Reset mid-request SHALL abandon the request; rd_data arriving after release SHALL be ignored.

Configuration
REQ-027 With RESULT_READER_CLAMP8_EN defined, each unmasked lane SHALL be saturated to signed 8-bit [-128,127] and sign-extended to DATA_WIDTH_ACCUM; without it lanes pass unmodified.

Verification
REQ-028 Rows=4, cols=16, addr=0x200, out_ready=1, row i lanes = i*100+lane -> rd_en cycles 1-4 addr 0x200-0x203, beats cycles 3-6 exact, out_last on beat 3, done cycle 7.
REQ-029 Rows=2, cols=8, all lanes 5 -> lanes 0-7 = 5, lanes 8-15 = 0.
REQ-030 Rows=16, out_ready toggling 1/0 -> 16 beats in order, no loss/duplication, in-flight+FIFO never >3.
REQ-031 Addr=0x3FE, rows=4 -> rd_addr 0x3FE, 0x3FF, 0x000, 0x001.
REQ-032 Rows=0 -> no rd_en, no out_valid, done one cycle after accept; rows=8 with rst_n pulsed low after beat 2 -> outputs zero instantly, next request runs clean.
REQ-033 CLAMP8 on: lanes 1000, -1000, 50 -> 127, -128, 50; off -> 1000, -1000, 50.
